// File: rtl/clock_mode_controller.sv
// Front-panel mode controller: conditions the mode/sel/inc buttons and runs the
// NORMAL -> ADJ_TIME -> ADJ_ALARM state machine with field select, auto-repeat and idle timeout.
module clock_mode_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_SEC     = 30,
    parameter int unsigned REPEAT_DELAY    = 2,
    parameter int unsigned TIME_FIELDS     = 6,
    parameter int unsigned ALARM_FIELDS    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_inc,
    output logic [1:0] mode_state,
    output logic [2:0] field_sel,
    output logic       inc_pulse,
    output logic       stop_count,
    output logic       blink,
    output logic       commit,
    output logic       timeout_evt
);
    localparam int unsigned BTN_N  = 3;
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_SEC + 1);
    localparam int unsigned REP_W  = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned FLD_W  = 3;

    typedef enum logic [1:0] {
        NORMAL    = 2'b00,
        ADJ_TIME  = 2'b01,
        ADJ_ALARM = 2'b10,
        ILLEGAL   = 2'b11
    } state_t;

    // Button index: 0 = mode, 1 = sel, 2 = inc
    logic [BTN_N-1:0] btn_raw, sync1_q, sync2_q, level_q, level_d_q, press;
    logic [DB_W-1:0]  db_cnt_q [BTN_N];

    state_t            state_q, state_n;
    logic [FLD_W-1:0]  field_q, field_n;
    logic [IDLE_W-1:0] idle_q, idle_n;
    logic [REP_W-1:0]  rep_q, rep_n;
    logic              armed_q, armed_n;
    logic              inc_q, inc_n, stop_q, stop_n, blink_q, blink_n;
    logic              commit_q, commit_n, timeout_q, timeout_n;
    logic              mode_evt, sel_evt, inc_evt, any_press, adjust, inc_held, idle_exp, trans;

    assign btn_raw = {btn_inc, btn_sel, btn_mode};

    // Two-flop synchroniser followed by a consecutive-sample debounce counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            level_d_q <= '0;
            for (int i = 0; i < BTN_N; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            level_d_q <= level_q;
            for (int i = 0; i < BTN_N; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt_q[i] <= '0;
                    level_q[i]  <= sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign press     = level_q & ~level_d_q;
    assign mode_evt  = press[0];
    assign sel_evt   = press[1] & ~press[0];
    assign inc_evt   = press[2] & ~press[1] & ~press[0];
    assign any_press = |press;
    assign inc_held  = level_q[2];
    assign adjust    = (state_q == ADJ_TIME) || (state_q == ADJ_ALARM);
    // A press in the expiry cycle cancels the timeout
    assign idle_exp  = adjust && (idle_q == IDLE_W'(TIMEOUT_SEC)) && !any_press;

    always_comb begin
        state_n   = state_q;
        commit_n  = 1'b0;
        timeout_n = 1'b0;
        field_n   = field_q;
        idle_n    = idle_q;
        rep_n     = rep_q;
        armed_n   = armed_q;
        inc_n     = 1'b0;
        blink_n   = blink_q;

        case (state_q)
            NORMAL: begin
                if (mode_evt) state_n = ADJ_TIME;
            end
            ADJ_TIME: begin
                if (mode_evt) begin
                    state_n  = ADJ_ALARM;
                    commit_n = 1'b1;
                end else if (idle_exp) begin
                    state_n   = NORMAL;
                    commit_n  = 1'b1;
                    timeout_n = 1'b1;
                end
            end
            ADJ_ALARM: begin
                if (mode_evt || idle_exp) state_n = NORMAL;
                timeout_n = !mode_evt && idle_exp;
            end
            default: state_n = NORMAL;
        endcase

        trans  = (state_n != state_q);
        stop_n = (state_n == ADJ_TIME);

        if (trans) begin
            field_n = '0;
        end else if (sel_evt && state_q == ADJ_TIME) begin
            field_n = (field_q == FLD_W'(TIME_FIELDS - 1)) ? '0 : field_q + FLD_W'(1);
        end else if (sel_evt && state_q == ADJ_ALARM) begin
            field_n = (field_q == FLD_W'(ALARM_FIELDS - 1)) ? '0 : field_q + FLD_W'(1);
        end

        // Auto-repeat: armed by an accepted inc press, cancelled by release or sel/mode
        if (!inc_held || !adjust || press[0] || press[1]) begin
            armed_n = 1'b0;
            rep_n   = '0;
        end else if (inc_evt) begin
            armed_n = 1'b1;
            rep_n   = '0;
            inc_n   = 1'b1;
        end else if (armed_q && tick_1hz) begin
            if (rep_q == REP_W'(REPEAT_DELAY)) inc_n = 1'b1;
            else                               rep_n = rep_q + REP_W'(1);
        end

        if (any_press || trans) begin
            idle_n = '0;
        end else if (adjust && tick_1hz && !inc_held && idle_q != IDLE_W'(TIMEOUT_SEC)) begin
            idle_n = idle_q + IDLE_W'(1);
        end

        if (trans || !adjust) blink_n = 1'b0;
        else if (tick_1hz)    blink_n = ~blink_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= NORMAL;
            field_q   <= '0;
            idle_q    <= '0;
            rep_q     <= '0;
            armed_q   <= 1'b0;
            inc_q     <= 1'b0;
            stop_q    <= 1'b0;
            blink_q   <= 1'b0;
            commit_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            field_q   <= field_n;
            idle_q    <= idle_n;
            rep_q     <= rep_n;
            armed_q   <= armed_n;
            inc_q     <= inc_n;
            stop_q    <= stop_n;
            blink_q   <= blink_n;
            commit_q  <= commit_n;
            timeout_q <= timeout_n;
        end
    end

    assign mode_state  = state_q;
    assign field_sel   = field_q;
    assign inc_pulse   = inc_q;
    assign stop_count  = stop_q;
    assign blink       = blink_q;
    assign commit      = commit_q;
    assign timeout_evt = timeout_q;

endmodule
